// File: rtl/div_iter_unit.sv
// div_iter_unit: radix-2 restoring divider producing {remainder, quotient} with a one-cycle ready pulse
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 annul_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               r_state, w_state;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic [WIDTH-1:0]     r_dvd, w_dvd, r_dvs, w_dvs, r_rem, w_rem;
  logic                 r_neg_q, w_neg_q, r_neg_r, w_neg_r;
  logic [2*WIDTH-1:0]   r_result, w_result;
  logic [WIDTH-1:0]     w_abs1, w_abs2, w_rem_sh, w_rem_step, w_quo_step;
  logic                 w_ge;
  assign w_abs1     = (signed_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2     = (signed_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign w_rem_sh   = {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
  // the bit shifted out of the remainder is kept in the compare so divisors above 2^(WIDTH-1) still divide correctly
  assign w_ge       = r_rem[WIDTH-1] | (w_rem_sh >= r_dvs);
  assign w_rem_step = w_ge ? w_rem_sh - r_dvs : w_rem_sh;
  assign w_quo_step = {r_dvd[WIDTH-2:0], w_ge};
  assign result_o   = r_result;
  assign ready_o    = (r_state == DONE);
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_dvd    <= w_dvd;
      r_dvs    <= w_dvs;
      r_rem    <= w_rem;
      r_neg_q  <= w_neg_q;
      r_neg_r  <= w_neg_r;
      r_result <= w_result;
    end
  end
  // next-state: accept in IDLE, one quotient bit per RUN cycle, annul wins over the final step
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_dvd    = r_dvd;
    w_dvs    = r_dvs;
    w_rem    = r_rem;
    w_neg_q  = r_neg_q;
    w_neg_r  = r_neg_r;
    w_result = r_result;
    case (r_state)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state  = DONE;
            w_result = {opdata1_i, {WIDTH{1'b1}}};
          end else begin
            w_state = RUN;
            w_dvd   = w_abs1;
            w_dvs   = w_abs2;
            w_rem   = '0;
            w_cnt   = '0;
            w_neg_q = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            w_neg_r = signed_i & opdata1_i[WIDTH-1];
          end
        end
      end
      RUN: begin
        if (annul_i) begin
          w_state = IDLE;
        end else begin
          w_rem = w_rem_step;
          w_dvd = w_quo_step;
          w_cnt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            w_state  = DONE;
            w_result = {r_neg_r ? -w_rem_step : w_rem_step, r_neg_q ? -w_quo_step : w_quo_step};
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: directed checks of the iterative divider
module tb_div_iter_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  int vectors = 0;
  int miscompares = 0;

  div_iter_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i), .annul_i(annul_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res, output logic one_cycle);
    @(negedge clk);
    signed_i = sg; opdata1_i = a; opdata2_i = b; start_i = 1'b1; lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ready_o) break;
    end
    res = result_o;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    one_cycle = !ready_o;
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 0; signed_i = 0; annul_i = 0; opdata1_i = 0; opdata2_i = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if (ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    vectors++;
    if (result_o !== 64'd0) begin miscompares++; $display("FAIL reset_result got=%h exp=0", result_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu;
    int lat; logic [63:0] res; logic oc;
    do_div(1'b0, 32'd100, 32'd7, lat, res, oc);
    vectors++;
    if (lat !== 33) begin miscompares++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    vectors++;
    if (res !== {32'd2, 32'd14}) begin miscompares++; $display("FAIL divu_100_7 got=%h exp=%h", res, {32'd2, 32'd14}); end
    vectors++;
    if (oc !== 1'b1) begin miscompares++; $display("FAIL divu_pulse_width got=%b exp=1", oc); end
    do_div(1'b0, 32'hFFFFFFFF, 32'h10, lat, res, oc);
    vectors++;
    if (res !== {32'hF, 32'h0FFFFFFF}) begin miscompares++; $display("FAIL divu_big got=%h exp=%h", res, {32'hF, 32'h0FFFFFFF}); end
  endtask

  task automatic test_div_signed;
    int lat; logic [63:0] res; logic oc;
    do_div(1'b1, 32'hFFFFFF9C, 32'd7, lat, res, oc);
    vectors++;
    if (res !== {32'hFFFFFFFE, 32'hFFFFFFF2}) begin miscompares++; $display("FAIL div_neg100_7 got=%h exp=%h", res, {32'hFFFFFFFE, 32'hFFFFFFF2}); end
    do_div(1'b1, 32'd100, 32'hFFFFFFF9, lat, res, oc);
    vectors++;
    if (res !== {32'd2, 32'hFFFFFFF2}) begin miscompares++; $display("FAIL div_100_neg7 got=%h exp=%h", res, {32'd2, 32'hFFFFFFF2}); end
    vectors++;
    if (lat !== 33) begin miscompares++; $display("FAIL div_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_overflow;
    int lat; logic [63:0] res; logic oc;
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res, oc);
    vectors++;
    if (res !== {32'h0, 32'h80000000}) begin miscompares++; $display("FAIL div_overflow got=%h exp=%h", res, {32'h0, 32'h80000000}); end
    do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, lat, res, oc);
    vectors++;
    if (res !== {32'h80000000, 32'h0}) begin miscompares++; $display("FAIL divu_same_ops got=%h exp=%h", res, {32'h80000000, 32'h0}); end
  endtask

  task automatic test_div_zero;
    int lat; logic [63:0] res; logic oc;
    do_div(1'b0, 32'd5, 32'd0, lat, res, oc);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL divzero_latency got=%0d exp=1", lat); end
    vectors++;
    if (res !== {32'd5, 32'hFFFFFFFF}) begin miscompares++; $display("FAIL divzero_result got=%h exp=%h", res, {32'd5, 32'hFFFFFFFF}); end
    vectors++;
    if (oc !== 1'b1) begin miscompares++; $display("FAIL divzero_pulse_width got=%b exp=1", oc); end
  endtask

  task automatic test_annul;
    int lat, pulses; logic [63:0] res; logic oc;
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd2; start_i = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    pulses = 0;
    repeat (40) begin @(negedge clk); if (ready_o) pulses++; end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL annul_no_pulse got=%0d exp=0", pulses); end
    vectors++;
    if (result_o !== {32'd5, 32'hFFFFFFFF}) begin miscompares++; $display("FAIL annul_result_hold got=%h exp=%h", result_o, {32'd5, 32'hFFFFFFFF}); end
    do_div(1'b0, 32'd9, 32'd2, lat, res, oc);
    vectors++;
    if (res !== {32'd1, 32'd4} || lat !== 33) begin miscompares++; $display("FAIL annul_rerun got=%h lat=%0d exp=%h lat=33", res, lat, {32'd1, 32'd4}); end
  endtask

  task automatic test_start_drop;
    int lat;
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd6; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd3; signed_i = 1'b1;
    lat = 1;
    while (lat < 40 && !ready_o) begin @(posedge clk); lat++; @(negedge clk); end
    vectors++;
    if (lat !== 33) begin miscompares++; $display("FAIL start_drop_latency got=%0d exp=33", lat); end
    vectors++;
    if (result_o !== {32'd2, 32'd8}) begin miscompares++; $display("FAIL start_drop_result got=%h exp=%h", result_o, {32'd2, 32'd8}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc, n, p[2]; logic [63:0] r[2];
    @(negedge clk);
    signed_i = 1'b1; opdata1_i = 32'd20; opdata2_i = 32'd3; start_i = 1'b1;
    cyc = 0; n = 0; p[0] = 0; p[1] = 0; r[0] = '0; r[1] = '0;
    while (cyc < 100 && n < 2) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (ready_o) begin
        p[n] = cyc; r[n] = result_o; n++;
        opdata1_i = 32'd7; opdata2_i = 32'd7;
      end
    end
    start_i = 1'b0;
    vectors++;
    if (n !== 2) begin miscompares++; $display("FAIL b2b_pulse_count got=%0d exp=2", n); end
    vectors++;
    if (p[0] !== 33 || p[1] - p[0] !== 34) begin miscompares++; $display("FAIL b2b_spacing got=%0d,%0d exp=33,67", p[0], p[1]); end
    vectors++;
    if (r[0] !== {32'd2, 32'd6}) begin miscompares++; $display("FAIL b2b_first got=%h exp=%h", r[0], {32'd2, 32'd6}); end
    vectors++;
    if (r[1] !== {32'd0, 32'd1}) begin miscompares++; $display("FAIL b2b_second got=%h exp=%h", r[1], {32'd0, 32'd1}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int lat; logic [63:0] res; logic oc;
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (10) @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (result_o !== 64'd0 || ready_o !== 1'b0) begin miscompares++; $display("FAIL async_reset got=%h/%b exp=0/0", result_o, ready_o); end
    @(negedge clk);
    rst = 1'b0;
    do_div(1'b0, 32'd100, 32'd7, lat, res, oc);
    vectors++;
    if (res !== {32'd2, 32'd14} || lat !== 33) begin miscompares++; $display("FAIL post_reset_div got=%h lat=%0d exp=%h lat=33", res, lat, {32'd2, 32'd14}); end
  endtask

  initial begin
    test_reset;
    test_divu;
    test_div_signed;
    test_overflow;
    test_div_zero;
    test_annul;
    test_start_drop;
    test_back_to_back;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
